// File: rtl/regfile_writeback_arbiter.sv
// Register-file write port arbiter: primary writeback stream wins,
// long-latency results queue in a small FIFO with squash and pending mask.
module regfile_writeback_arbiter #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pri_we,
    input  logic [ADDR_W-1:0]          pri_reg,
    input  logic [DATA_W-1:0]          pri_data,
    input  logic                       sec_valid,
    output logic                       sec_ready,
    input  logic [ADDR_W-1:0]          sec_reg,
    input  logic [DATA_W-1:0]          sec_data,
    output logic                       RegWrite,
    output logic [ADDR_W-1:0]          WriteReg,
    output logic [DATA_W-1:0]          WriteData,
    output logic [31:0]                pend_mask,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] regQ  [DEPTH];
    logic [DATA_W-1:0] dataQ [DEPTH];
    logic [DEPTH-1:0]  liveQ;
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [CNT_W-1:0]  count;

    logic priHit;
    logic push;
    logic pop;
    logic pushLive;

    assign sec_ready  = rst_n && (count < FULL);
    assign priHit     = pri_we && (pri_reg != '0);
    assign push       = sec_valid && sec_ready && (sec_reg != '0);
    assign pop        = !priHit && (count != '0);
    assign pushLive   = !(priHit && (sec_reg == pri_reg));
    assign fifo_count = count;

    // Live bits are cleared on pop, so only occupied slots can contribute.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (liveQ[i]) begin
                pend_mask[regQ[i]] = 1'b1;
            end
        end
        pend_mask[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regQ[i]  <= '0;
                dataQ[i] <= '0;
            end
            liveQ     <= '0;
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (priHit && (regQ[i] == pri_reg)) begin
                    liveQ[i] <= 1'b0;
                end
            end
            if (pop) begin
                liveQ[rdPtr] <= 1'b0;
                rdPtr        <= rdPtr + PTR_W'(1);
            end
            // A same-cycle primary write to the same register is newer.
            if (push) begin
                regQ[wrPtr]  <= sec_reg;
                dataQ[wrPtr] <= sec_data;
                liveQ[wrPtr] <= pushLive;
                wrPtr        <= wrPtr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (priHit) begin
                RegWrite  <= 1'b1;
                WriteReg  <= pri_reg;
                WriteData <= pri_data;
            end else if (pop) begin
                RegWrite <= liveQ[rdPtr];
                if (liveQ[rdPtr]) begin
                    WriteReg  <= regQ[rdPtr];
                    WriteData <= dataQ[rdPtr];
                end
            end else begin
                RegWrite <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed bench for regfile_writeback_arbiter: priority, squash,
// full/wrap, r0 discard and asynchronous reset.
module tb_regfile_writeback_arbiter;

    logic        clk;
    logic        rst_n;
    logic        pri_we;
    logic [4:0]  pri_reg;
    logic [31:0] pri_data;
    logic        sec_valid;
    logic        sec_ready;
    logic [4:0]  sec_reg;
    logic [31:0] sec_data;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [31:0] pend_mask;
    logic [2:0]  fifo_count;

    int errors;
    int checks;

    regfile_writeback_arbiter #(
        .DEPTH(4), .DATA_W(32), .ADDR_W(5)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pri_we(pri_we), .pri_reg(pri_reg), .pri_data(pri_data),
        .sec_valid(sec_valid), .sec_ready(sec_ready),
        .sec_reg(sec_reg), .sec_data(sec_data),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .pend_mask(pend_mask), .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pri_we    = 1'b0;
        pri_reg   = '0;
        pri_data  = '0;
        sec_valid = 1'b0;
        sec_reg   = '0;
        sec_data  = '0;
    endtask

    task automatic test_reset();
        checks++;
        if ({RegWrite, WriteReg, WriteData} !== 38'd0) begin
            errors++;
            $display("FAIL reset_out: got %0b/%0d/%h want 0/0/0",
                     RegWrite, WriteReg, WriteData);
        end
        checks++;
        if (fifo_count !== 3'd0 || pend_mask !== 32'd0) begin
            errors++;
            $display("FAIL reset_fifo: got cnt=%0d pend=%h want 0/0",
                     fifo_count, pend_mask);
        end
        checks++;
        if (sec_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %0b want 0", sec_ready);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (sec_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_ready: got %0b want 1", sec_ready);
        end
    endtask

    task automatic test_primary();
        pri_we = 1'b1; pri_reg = 5'd7; pri_data = 32'hDEADBEEF;
        tick();
        checks++;
        if (RegWrite !== 1'b1 || WriteReg !== 5'd7 || WriteData !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL pri_r7: got %0b/%0d/%h want 1/7/deadbeef",
                     RegWrite, WriteReg, WriteData);
        end
        pri_reg = 5'd0; pri_data = 32'h12345678;
        tick();
        checks++;
        if (RegWrite !== 1'b0 || WriteReg !== 5'd7 || WriteData !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL pri_r0: got %0b/%0d/%h want 0/7/deadbeef",
                     RegWrite, WriteReg, WriteData);
        end
        idle();
    endtask

    task automatic test_priority();
        logic [31:0] expData [3];
        expData[0] = 32'h900; expData[1] = 32'h901; expData[2] = 32'h902;
        for (int c = 0; c < 3; c++) begin
            pri_we = 1'b1; pri_reg = 5'd9; pri_data = expData[c];
            sec_valid = (c < 2);
            sec_reg   = (c == 0) ? 5'd3 : 5'd4;
            sec_data  = (c == 0) ? 32'h11 : 32'h22;
            tick();
            checks++;
            if (RegWrite !== 1'b1 || WriteReg !== 5'd9 || WriteData !== expData[c]) begin
                errors++;
                $display("FAIL prio_pri%0d: got %0b/%0d/%h want 1/9/%h",
                         c, RegWrite, WriteReg, WriteData, expData[c]);
            end
        end
        checks++;
        if (pend_mask !== 32'h18 || fifo_count !== 3'd2) begin
            errors++;
            $display("FAIL prio_pend: got pend=%h cnt=%0d want 18/2",
                     pend_mask, fifo_count);
        end
        idle();
        tick();
        checks++;
        if (RegWrite !== 1'b1 || WriteReg !== 5'd3 || WriteData !== 32'h11
            || pend_mask !== 32'h10) begin
            errors++;
            $display("FAIL prio_pop3: got %0b/%0d/%h pend=%h want 1/3/11 pend=10",
                     RegWrite, WriteReg, WriteData, pend_mask);
        end
        tick();
        checks++;
        if (RegWrite !== 1'b1 || WriteReg !== 5'd4 || WriteData !== 32'h22
            || pend_mask !== 32'h0 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL prio_pop4: got %0b/%0d/%h pend=%h cnt=%0d want 1/4/22/0/0",
                     RegWrite, WriteReg, WriteData, pend_mask, fifo_count);
        end
        tick();
        checks++;
        if (RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL prio_idle: got RegWrite=%0b want 0", RegWrite);
        end
    endtask

    task automatic test_squash();
        sec_valid = 1'b1; sec_reg = 5'd5; sec_data = 32'hAA;
        tick();
        checks++;
        if (pend_mask !== 32'h20 || fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL sq_enq: got pend=%h cnt=%0d want 20/1", pend_mask, fifo_count);
        end
        idle();
        pri_we = 1'b1; pri_reg = 5'd5; pri_data = 32'hBB;
        tick();
        checks++;
        if (RegWrite !== 1'b1 || WriteData !== 32'hBB || pend_mask !== 32'h0
            || fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL sq_pri: got %0b/%h pend=%h cnt=%0d want 1/bb/0/1",
                     RegWrite, WriteData, pend_mask, fifo_count);
        end
        idle();
        tick();
        checks++;
        if (RegWrite !== 1'b0 || WriteData !== 32'hBB || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL sq_pop: got %0b/%h cnt=%0d want 0/bb/0",
                     RegWrite, WriteData, fifo_count);
        end
    endtask

    task automatic test_squash_same();
        pri_we = 1'b1; pri_reg = 5'd5; pri_data = 32'hCC;
        sec_valid = 1'b1; sec_reg = 5'd5; sec_data = 32'hAA;
        tick();
        checks++;
        if (RegWrite !== 1'b1 || WriteData !== 32'hCC || pend_mask !== 32'h0
            || fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL sqs_edge: got %0b/%h pend=%h cnt=%0d want 1/cc/0/1",
                     RegWrite, WriteData, pend_mask, fifo_count);
        end
        idle();
        tick();
        checks++;
        if (RegWrite !== 1'b0 || WriteData !== 32'hCC || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL sqs_pop: got %0b/%h cnt=%0d want 0/cc/0",
                     RegWrite, WriteData, fifo_count);
        end
    endtask

    task automatic test_full_wrap();
        int k;
        int p;
        int cyc;
        logic acc;
        k = 0;
        for (int i = 0; i < 4; i++) begin
            pri_we = 1'b1; pri_reg = 5'd9; pri_data = 32'h999;
            sec_valid = 1'b1; sec_reg = 5'(10 + k); sec_data = 32'h100 + k;
            tick();
            k++;
        end
        checks++;
        if (fifo_count !== 3'd4 || sec_ready !== 1'b0 || pend_mask !== 32'h3C00) begin
            errors++;
            $display("FAIL full: got cnt=%0d rdy=%0b pend=%h want 4/0/3c00",
                     fifo_count, sec_ready, pend_mask);
        end
        pri_we = 1'b0;
        p = 0;
        cyc = 0;
        while (p < 14 && cyc < 60) begin
            sec_valid = (k < 14);
            sec_reg   = 5'(10 + k);
            sec_data  = 32'h100 + k;
            acc = sec_valid && sec_ready;
            tick();
            cyc++;
            if (acc) k++;
            if (RegWrite === 1'b1) begin
                checks++;
                if (WriteReg !== 5'(10 + p) || WriteData !== 32'h100 + p) begin
                    errors++;
                    $display("FAIL wrap_order%0d: got %0d/%h want %0d/%h",
                             p, WriteReg, WriteData, 10 + p, 32'h100 + p);
                end
                p++;
            end
        end
        checks++;
        if (p != 14) begin
            errors++;
            $display("FAIL wrap_count: got %0d writes want 14", p);
        end
        idle();
        tick();
        checks++;
        if (RegWrite !== 1'b0 || fifo_count !== 3'd0 || pend_mask !== 32'h0) begin
            errors++;
            $display("FAIL wrap_drain: got %0b cnt=%0d pend=%h want 0/0/0",
                     RegWrite, fifo_count, pend_mask);
        end
    endtask

    task automatic test_r0();
        checks++;
        if (sec_ready !== 1'b1) begin
            errors++;
            $display("FAIL r0_ready: got %0b want 1", sec_ready);
        end
        sec_valid = 1'b1; sec_reg = 5'd0; sec_data = 32'h55;
        tick();
        idle();
        checks++;
        if (fifo_count !== 3'd0 || RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL r0_push: got cnt=%0d we=%0b want 0/0", fifo_count, RegWrite);
        end
        tick();
        checks++;
        if (RegWrite !== 1'b0 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL r0_write: got we=%0b cnt=%0d want 0/0", RegWrite, fifo_count);
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 3; i++) begin
            pri_we = 1'b1; pri_reg = 5'd9; pri_data = 32'h777;
            sec_valid = 1'b1; sec_reg = 5'(1 + i); sec_data = 32'h40 + i;
            tick();
        end
        checks++;
        if (fifo_count !== 3'd3 || pend_mask !== 32'hE || RegWrite !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: got cnt=%0d pend=%h we=%0b want 3/e/1",
                     fifo_count, pend_mask, RegWrite);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({RegWrite, WriteReg, WriteData} !== 38'd0 || fifo_count !== 3'd0
            || pend_mask !== 32'd0 || sec_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got %0b/%0d/%h cnt=%0d pend=%h rdy=%0b want all 0",
                     RegWrite, WriteReg, WriteData, fifo_count, pend_mask, sec_ready);
        end
        idle();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (sec_ready !== 1'b1 || RegWrite !== 1'b0 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL mid_release: got rdy=%0b we=%0b cnt=%0d want 1/0/0",
                     sec_ready, RegWrite, fifo_count);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        idle();
        tick();
        tick();
        test_reset();
        test_primary();
        test_priority();
        test_squash();
        test_squash_same();
        test_full_wrap();
        test_r0();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_writeback_arbiter.md
# regfile_writeback_arbiter

Write-side front end for the 32x32 register file: merges the single-cycle pipeline writeback stream (primary) with results from long-latency units such as mult/div (secondary) into the register file's single write port. Secondary results are buffered in a small FIFO. The block keeps a per-register pending mask for the hazard unit and squashes stale buffered writes that a newer primary write has overtaken. Its registered outputs drive the register file's RegWrite/WriteReg/WriteData directly.

## Interface
- DEPTH, 4, secondary FIFO entries; power of two, >= 2
- DATA_W, 32, data width
- ADDR_W, 5, register index width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- pri_we  in  1  primary write request (pipeline WB stage)
- pri_reg  in  ADDR_W  primary destination register
- pri_data  in  DATA_W  primary write data
- sec_valid  in  1  secondary result valid
- sec_ready  out  1  FIFO can accept a secondary result this cycle
- sec_reg  in  ADDR_W  secondary destination register
- sec_data  in  DATA_W  secondary write data
- RegWrite  out  1  register file write enable (registered)
- WriteReg  out  ADDR_W  register file write index (registered)
- WriteData  out  DATA_W  register file write data (registered)
- pend_mask  out  32  bit r = 1 when a live FIFO entry targets register r
- fifo_count  out  $clog2(DEPTH+1)  occupied FIFO entries, live plus squashed

## Operation
- Reset (rst_n low, asynchronous):
  - RegWrite=0, WriteReg=0, WriteData=0.
  - FIFO empty, pointers=0, fifo_count=0, pend_mask=0.
  - sec_ready=0 while in reset.
- sec_ready = (fifo_count < DEPTH) and not in reset. It is a function of registered count only, with no combinational path from same-cycle pops.
- Enqueue: on sec_valid && sec_ready:
  - If sec_reg != 0, push {reg, data, live=1}.
  - If sec_reg == 0, the result is accepted and discarded, with no push.
- Output arbitration, evaluated each cycle, result registered:
  - Primary first. If pri_we && pri_reg != 0, next outputs are RegWrite=1, WriteReg=pri_reg, WriteData=pri_data. The FIFO does not pop.
  - Otherwise, if the FIFO is non-empty, pop the head. A live head drives RegWrite=1 with its reg/data. A squashed head drives RegWrite=0.
  - Otherwise RegWrite=0. WriteReg/WriteData hold their last values.
- pri_we with pri_reg == 0 is ignored: no write, no squash, and the FIFO may pop that cycle.
- Squash: a primary write to register X (X != 0) clears the live bit of every FIFO entry targeting X.
  - This covers an entry enqueued in the same cycle, which is pushed already squashed. The primary write is always the newer value.
- pend_mask: OR over live entries of the one-hot of reg. Bit 0 is always 0. Derived from registered state.
- Simultaneous push and pop: count is unchanged and pointers both advance. Pointers wrap modulo DEPTH.
- Secondary results may starve while the primary writes every cycle. Backpressure via sec_ready is the only protection.

## Timing
- Primary latency: request in cycle N, write presented on the outputs in cycle N+1. The register file captures it during N+1.
- Secondary minimum latency: accepted at edge ending cycle N, popped in N+1, outputs valid in N+2.
- Throughput: one register-file write per cycle. One enqueue per cycle.
- fifo_count and pend_mask update on the same edge as the push/pop/squash that changes them.
- If reset asserts mid-operation, all queued entries are lost and outputs clear immediately, without waiting for a clock edge.
- Full-FIFO hold: with fifo_count=DEPTH and sec_valid high, nothing is accepted. The source must hold its data until sec_ready rises, one cycle after a pop.

## Test plan
- Reset: drive rst_n low mid-stream with 3 entries queued -> outputs 0, fifo_count=0, pend_mask=0 immediately. After release, sec_ready=1 on the first edge.
- Primary path: pri_we=1, pri_reg=7, pri_data=0xDEADBEEF in cycle N -> RegWrite=1, WriteReg=7, WriteData=0xDEADBEEF in N+1. Same stimulus with pri_reg=0 -> RegWrite=0.
- Secondary and priority:
  - Enqueue reg 3 = 0x11 and reg 4 = 0x22 while pri_we is held high to reg 9 for 3 cycles -> pend_mask=0x18 and three writes to reg 9.
  - Then reg 3 writes, then reg 4, in consecutive cycles, and pend_mask returns to 0.
- Squash:
  - Enqueue reg 5 = 0xAA, then primary writes reg 5 = 0xBB -> pend_mask bit 5 clears on that edge.
  - The later pop produces RegWrite=0, so the final value is 0xBB.
  - Repeat with enqueue and primary in the same cycle, with the same result.
- Full/wrap:
  - Push DEPTH entries with pri_we high -> sec_ready=0 and fifo_count=4.
  - Push and pop 10 more entries -> pointer wrap, FIFO order preserved, no loss or duplication.
- r0: sec_valid with sec_reg=0 -> accepted, fifo_count unchanged, no write ever issued.
